// File: rtl/rotate_issue_stage.sv
// Operand FIFO feeding an external combinational rotator, with a registered output stage.
// Optional feature: define ROT_DONE_CNT_EN to build the accepted-result counter on done_cnt.
module rotate_issue_stage #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              a,
    input  logic [31:0]              b,
    output logic [31:0]              rot_a,
    output logic [31:0]              rot_b,
    input  logic [31:0]              rot_o,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              o,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              done_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ostate_e;

    logic [36:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [31:0]   o_r;
    ostate_e       state_r;
    ostate_e       state_s;

    logic          push_s;
    logic          pop_s;
    logic          in_ready_s;
    logic          out_valid_s;
    logic          fifo_empty_s;
    logic [36:0]   head_s;
    logic          unused_b_s;

    // Only the low five bits of the amount matter to a 32-bit rotate.
    assign unused_b_s   = ^b[31:5];

    assign fifo_empty_s = (level_r == {LW{1'b0}});
    assign in_ready_s   = (level_r != LW'(DEPTH));
    assign out_valid_s  = (state_r == ST_FULL);
    assign push_s       = in_valid & in_ready_s;
    assign pop_s        = ~fifo_empty_s & (~out_valid_s | out_ready);
    assign head_s       = mem_r[rd_ptr_r];

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign o         = o_r;
    assign level     = level_r;

    // Head presentation to the rotator; zeros when nothing is queued.
    always_comb begin
        rot_a = 32'h0000_0000;
        rot_b = 32'h0000_0000;
        if (!fifo_empty_s) begin
            rot_a = head_s[36:5];
            rot_b = {27'b0, head_s[4:0]};
        end else begin
            rot_a = 32'h0000_0000;
            rot_b = 32'h0000_0000;
        end
    end

    // FIFO storage write; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {a, b[4:0]};
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Output-stage next state: a pop always refills, a bare accept drains.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (pop_s) begin
                    state_s = ST_FULL;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_ready && !pop_s) begin
                    state_s = ST_EMPTY;
                end else begin
                    state_s = ST_FULL;
                end
            end
            default: state_s = ST_EMPTY;
        endcase
    end

    // Output-stage state register and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
            o_r     <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            if (pop_s) begin
                o_r <= rot_o;
            end
        end
    end

`ifdef ROT_DONE_CNT_EN
    logic [15:0] done_cnt_r;

    // Accepted-result counter, wraps at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt_r <= 16'h0000;
        end else if (out_valid_s && out_ready) begin
            done_cnt_r <= done_cnt_r + 16'h0001;
        end
    end

    assign done_cnt = done_cnt_r;
`else
    assign done_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_rotate_issue_stage.sv
// Scoreboard bench for rotate_issue_stage with a behavioural rotate-left model on rot_o.
module tb_rotate_issue_stage;

    localparam int DEPTH = 4;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            a;
    logic [31:0]            b;
    logic [31:0]            rot_a;
    logic [31:0]            rot_b;
    logic [31:0]            rot_o;
    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            o;
    logic [$clog2(DEPTH):0] level;
    logic [15:0]            done_cnt;

    int          chk_cnt;
    int          pass_cnt;
    int          hs_cnt;
    logic [31:0] exp_q[$];

    rotate_issue_stage #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .rot_a     (rot_a),
        .rot_b     (rot_b),
        .rot_o     (rot_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o),
        .level     (level),
        .done_cnt  (done_cnt)
    );

    function automatic logic [31:0] rotl(input logic [31:0] v, input logic [4:0] n);
        logic [63:0] t;
        t = {v, v} << n;
        return t[63:32];
    endfunction

    assign rot_o = rotl(rot_a, rot_b[4:0]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: handshakes seen at the negedge complete on the next posedge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(rotl(a, b[4:0]));
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_result", o, 32'hxxxx_xxxx);
                end else begin
                    check("result_order", o, exp_q.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        step();
        step();
        rst_n  = 1'b1;
        hs_cnt = 0;
    endtask

    initial begin
        chk_cnt   = 0;
        pass_cnt  = 0;
        hs_cnt    = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 32'h0;
        b         = 32'h0;
        rst_n     = 1'b0;
        step();
        step();
        check("rst_in_ready",  {31'b0, in_ready},  32'h1);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_level",     32'(level),         32'h0);
        check("rst_o",         o,                  32'h0);
        check("rst_done_cnt",  32'(done_cnt),      32'h0);
        check("rst_rot_a",     rot_a,              32'h0);
        check("rst_rot_b",     rot_b,              32'h0);
        rst_n = 1'b1;
        step();

        // Single op latency
        in_valid = 1'b1; out_ready = 1'b1; a = 32'h8000_0001; b = 32'h0000_0001;
        step();
        in_valid = 1'b0;
        check("single_rot_a",      rot_a,              32'h8000_0001);
        check("single_rot_b",      rot_b,              32'h0000_0001);
        check("single_valid_k",    {31'b0, out_valid}, 32'h0);
        step();
        check("single_valid_k1",   {31'b0, out_valid}, 32'h1);
        check("single_o",          o,                  32'h0000_0003);
        step();
        check("single_valid_k2",   {31'b0, out_valid}, 32'h0);

        // Amount masking
        in_valid = 1'b1; a = 32'h0000_0001; b = 32'hFFFF_FFE5;
        step();
        in_valid = 1'b0;
        check("mask_rot_b", rot_b, 32'h0000_0005);
        step();
        check("mask_o",     o,     32'h0000_0020);
        in_valid = 1'b1; a = 32'h1234_5678; b = 32'h0;
        step();
        in_valid = 1'b0;
        step();
        check("zero_amt_o", o,     32'h1234_5678);
        step();

        // Backpressure: six offered, five held
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom;
            step();
        end
        in_valid = 1'b0;
        check("bp_level",     32'(level),         32'h4);
        check("bp_out_valid", {31'b0, out_valid}, 32'h1);
        check("bp_in_ready",  {31'b0, in_ready},  32'h0);
        check("bp_queued",    exp_q.size(),       32'h5);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_drain_valid", {31'b0, out_valid}, 32'h1);
            step();
        end
        check("bp_drained",  {31'b0, out_valid}, 32'h0);
        check("bp_sb_empty", exp_q.size(),       32'h0);

        // Streaming
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom;
            step();
            check("stream_level_le1", {31'b0, (level <= 3'd1)}, 32'h1);
        end
        in_valid = 1'b0;
        step();
        step();
        check("stream_sb_empty", exp_q.size(), 32'h0);
        check("stream_hs",       hs_cnt,       32'd100);
`ifdef ROT_DONE_CNT_EN
        check("stream_done_cnt", 32'(done_cnt), 32'd100);
`else
        check("stream_done_cnt", 32'(done_cnt), 32'd0);
`endif

        // Mid-op reset
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom;
            step();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mrst_out_valid", {31'b0, out_valid}, 32'h0);
        check("mrst_level",     32'(level),         32'h0);
        check("mrst_o",         o,                  32'h0);
        check("mrst_in_ready",  {31'b0, in_ready},  32'h1);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mrst_no_stale", {31'b0, out_valid}, 32'h0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
